fifo_pop_serializer: RTL

Consumer (pop side) for the dual-clock FIFO. Runs on the FIFO's pop clock.
- Drains words from the FIFO whenever it is not empty and the block is enabled.
- Sends each word as an asynchronous serial frame: start bit, data bits LSB-first, optional even parity, then stop bit.
- Registered pop/handshake outputs, so the FIFO sees clean single-cycle pop pulses.

---
 rtl/fifo_pop_serializer_pkg.sv | 22 ++
 rtl/fifo_pop_serializer_baud_tick_counter.sv | 31 +++
 rtl/fifo_pop_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_pop_serializer_pkg.sv
// Shared types and helpers for the FIFO pop-side serializer.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Smallest r with 2**r >= value; constant-evaluated for register widths.
  function automatic int CeilLog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_pop_serializer_baud_tick_counter.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last cycle of each bit.
module baud_tick_counter
  import fifo_serial_pkg::*;
#(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CeilLog2(BAUD_DIV) < 1) ? 1 : CeilLog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
    end
  end

  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/fifo_pop_serializer.sv
// Drains a show-ahead FIFO and sends each word as a start/data/[parity]/stop serial frame.
module fifo_pop_serializer
  import fifo_serial_pkg::*;
#(
  parameter int WORDLENGHT = 8,
  parameter int BAUD_DIV   = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  synch_rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [WORDLENGHT-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  word_done
);

  localparam int BW = CeilLog2(WORDLENGHT) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORDLENGHT - 1);

  state_t                r_state;
  logic [WORDLENGHT-1:0] r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_parity;
  logic                  r_serial_out;
  logic                  r_fifo_pop;
  logic                  r_busy;
  logic                  r_word_done;

  logic                  w_tick;
  logic                  w_load;
  logic [WORDLENGHT-1:0] w_shift_next;

  // A new word is taken only from IDLE or on the very last STOP cycle.
  assign w_load       = enable && !fifo_empty &&
                        ((r_state == IDLE) || ((r_state == STOP) && w_tick));
  assign w_shift_next = r_shift >> 1;

  baud_tick_counter #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (synch_rst || w_load),
    .enable (r_state != IDLE),
    .tick   (w_tick)
  );

  // Outputs are registered, so each transition loads the value of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_serial_out <= 1'b1;
      r_fifo_pop   <= 1'b0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
    end else if (synch_rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_serial_out <= 1'b1;
      r_fifo_pop   <= 1'b0;
      r_busy       <= 1'b0;
      r_word_done  <= 1'b0;
    end else begin
      r_fifo_pop  <= 1'b0;
      r_word_done <= 1'b0;
      if (w_load) begin
        r_shift      <= fifo_data;
        r_parity     <= ^fifo_data;
        r_bit_cnt    <= '0;
        r_state      <= START;
        r_fifo_pop   <= 1'b1;
        r_serial_out <= 1'b0;
        r_busy       <= 1'b1;
        r_word_done  <= (r_state == STOP);
      end else if (w_tick) begin
        case (r_state)
          START: begin
            r_state      <= DATA;
            r_serial_out <= r_shift[0];
          end
          DATA: begin
            r_shift <= w_shift_next;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state      <= PARITY;
                r_serial_out <= r_parity;
              end else begin
                r_state      <= STOP;
                r_serial_out <= 1'b1;
              end
            end else begin
              r_bit_cnt    <= r_bit_cnt + BW'(1);
              r_serial_out <= w_shift_next[0];
            end
          end
          PARITY: begin
            r_state      <= STOP;
            r_serial_out <= 1'b1;
          end
          STOP: begin
            r_state      <= IDLE;
            r_serial_out <= 1'b1;
            r_busy       <= 1'b0;
            r_word_done  <= 1'b1;
          end
          default: begin
            r_state      <= IDLE;
            r_serial_out <= 1'b1;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fifo_pop   = r_fifo_pop;
  assign serial_out = r_serial_out;
  assign busy       = r_busy;
  assign word_done  = r_word_done;

endmodule
